// File: rtl/register_file_mp_if.sv
// register_file_mp bus: phase enables, read/write ports, LED shadow.
// Parameters must match those of the attached register_file_mp.
interface register_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int LED_WIDTH  = 7
);
    logic [1:0]                     CLK_EN;
    logic [NUM_READ*ADDR_WIDTH-1:0] READ_ADDRESS;
    logic [ADDR_WIDTH-1:0]          WRITE_ADDRESS;
    logic                           WRITE_ENABLE;
    logic [DATA_WIDTH-1:0]          WRITE_DATA;
    logic [NUM_READ*DATA_WIDTH-1:0] READ_DATA;
    logic [LED_WIDTH-1:0]           LEDS;

    modport master (
        output CLK_EN, READ_ADDRESS, WRITE_ADDRESS,
        output WRITE_ENABLE, WRITE_DATA,
        input  READ_DATA, LEDS
    );

    modport slave (
        input  CLK_EN, READ_ADDRESS, WRITE_ADDRESS,
        input  WRITE_ENABLE, WRITE_DATA,
        output READ_DATA, LEDS
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port flop register file with two-phase enables,
// optional zero register, optional write-first bypass and LED shadow.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1,
    parameter int LED_ADDR   = 3,
    parameter int LED_WIDTH  = 7
) (
    input logic               CLK,
    input logic               RST_N,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("register_file_mp: NUM_READ must be 1..4");
    end
    if (LED_WIDTH > DATA_WIDTH) begin : g_bad_led_width
        $error("register_file_mp: LED_WIDTH exceeds DATA_WIDTH");
    end

    logic                  rd_en;
    logic                  wr_go;
    logic                  wr_arr;
    logic                  led_hit;
    logic [DATA_WIDTH-1:0] mem     [DEPTH];
    logic [DATA_WIDTH-1:0] rd_next [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_q    [NUM_READ];

    assign rd_en   = bus.CLK_EN[0] | bus.CLK_EN[1];
    assign wr_go   = bus.CLK_EN[1] & bus.WRITE_ENABLE;
    // Register 0 stays zero when hardwired; the LED path still sees it.
    assign wr_arr  = wr_go &
                     ~(ZERO_REG & (bus.WRITE_ADDRESS == '0));
    assign led_hit = wr_go &
                     (bus.WRITE_ADDRESS == ADDR_WIDTH'(LED_ADDR));

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  zero_hit;
        logic                  fwd_hit;

        assign ra       = bus.READ_ADDRESS[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = ZERO_REG & (ra == '0);
        assign fwd_hit  = BYPASS & wr_go & (bus.WRITE_ADDRESS == ra);
        assign rd_next[g] = zero_hit ? '0 :
                            fwd_hit  ? bus.WRITE_DATA : mem[ra];
        assign bus.READ_DATA[g*DATA_WIDTH +: DATA_WIDTH] = rd_q[g];
    end

    // Storage array: cleared on reset, written in the commit phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_arr) begin
            mem[bus.WRITE_ADDRESS] <= bus.WRITE_DATA;
        end
    end

    // Read capture registers, one per port, held while no phase is active.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int p = 0; p < NUM_READ; p++) rd_q[p] <= '0;
        end else if (rd_en) begin
            for (int p = 0; p < NUM_READ; p++) rd_q[p] <= rd_next[p];
        end
    end

    // LED shadow: low bits of any committed write to LED_ADDR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.LEDS <= '0;
        end else if (led_hit) begin
            bus.LEDS <= bus.WRITE_DATA[LED_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: bypass and read-first
// 32-bit instances plus a 4-port 16-bit instance, scoreboard checked.
module tb_register_file_mp;
    logic CLK;
    logic RST_N;

    register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5),
                          .NUM_READ(2), .LED_WIDTH(7)) b0 ();
    register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5),
                          .NUM_READ(2), .LED_WIDTH(7)) b1 ();
    register_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3),
                          .NUM_READ(4), .LED_WIDTH(7)) b2 ();

    register_file_mp #(.BYPASS(1'b1)) u0 (
        .CLK(CLK), .RST_N(RST_N), .bus(b0)
    );
    register_file_mp #(.BYPASS(1'b0)) u1 (
        .CLK(CLK), .RST_N(RST_N), .bus(b1)
    );
    register_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3),
                       .NUM_READ(4)) u2 (
        .CLK(CLK), .RST_N(RST_N), .bus(b2)
    );

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // port 8 selects LEDS
    function automatic logic [31:0] observe(input int dut, input int port);
        logic [31:0] v;
        v = '0;
        case (dut)
            0: v = (port == 8) ? 32'(b0.LEDS) : b0.READ_DATA[port*32 +: 32];
            1: v = (port == 8) ? 32'(b1.LEDS) : b1.READ_DATA[port*32 +: 32];
            default:
                v = (port == 8) ? 32'(b2.LEDS) : 32'(b2.READ_DATA[port*16 +: 16]);
        endcase
        return v;
    endfunction

    task automatic expect_val(input string tag, input int dut,
                              input int port, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.dut = dut; e.port = port; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_both(input string tag, input int port,
                               input logic [31:0] v);
        expect_val({tag, "_u0"}, 0, port, v);
        expect_val({tag, "_u1"}, 1, port, v);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.dut, e.port), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drain();
    endtask

    task automatic drive(input logic [1:0] en, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        b0.CLK_EN = en; b0.WRITE_ENABLE = we;
        b0.WRITE_ADDRESS = wa; b0.WRITE_DATA = wd;
        b0.READ_ADDRESS = {r1, r0};
        b1.CLK_EN = en; b1.WRITE_ENABLE = we;
        b1.WRITE_ADDRESS = wa; b1.WRITE_DATA = wd;
        b1.READ_ADDRESS = {r1, r0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0;
        drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        b2.CLK_EN = 2'b00; b2.WRITE_ENABLE = 1'b0;
        b2.WRITE_ADDRESS = '0; b2.WRITE_DATA = '0;
        b2.READ_ADDRESS = '0;
        repeat (2) @(posedge CLK);
        #1;
        expect_both("rst_rd0", 0, 32'h0);
        expect_both("rst_rd1", 1, 32'h0);
        expect_both("rst_led", 8, 32'h0);
        drain();
        #2 RST_N = 1'b1;

        // reset clears array, reads and LEDS mid-cycle
        drive(2'b10, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        tick();
        drive(2'b10, 1'b1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
        expect_both("pre_led", 8, 32'h6F);
        tick();
        drive(2'b01, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
        expect_both("pre_r5", 0, 32'hDEADBEEF);
        expect_both("pre_r3", 1, 32'hDEADBEEF);
        tick();
        #2 RST_N = 1'b0;
        #1;
        expect_both("arst_rd0", 0, 32'h0);
        expect_both("arst_rd1", 1, 32'h0);
        expect_both("arst_led", 8, 32'h0);
        drain();
        #2 RST_N = 1'b1;
        expect_both("post_r5", 0, 32'h0);
        expect_both("post_r3", 1, 32'h0);
        tick();

        // basic write then read, then freeze
        drive(2'b10, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
        expect_both("wr7_rd0", 0, 32'h0);
        tick();
        drive(2'b01, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        expect_both("r7_p0", 0, 32'h12345678);
        expect_both("r7_p1", 1, 32'h12345678);
        tick();
        drive(2'b00, 1'b1, 5'd7, 32'hCAFEF00D, 5'd5, 5'd3);
        expect_both("frz_p0", 0, 32'h12345678);
        expect_both("frz_p1", 1, 32'h12345678);
        expect_both("frz_led", 8, 32'h0);
        tick();
        drive(2'b01, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        expect_both("frz_nowr", 0, 32'h12345678);
        tick();

        // zero register, including same-edge read under bypass
        drive(2'b10, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_both("z_same0", 0, 32'h0);
        expect_both("z_same1", 1, 32'h0);
        tick();
        drive(2'b01, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_both("z_rd0", 0, 32'h0);
        expect_both("z_rd1", 1, 32'h0);
        tick();

        // bypass versus read-first
        drive(2'b10, 1'b1, 5'd9, 32'h11111111, 5'd7, 5'd0);
        tick();
        drive(2'b10, 1'b1, 5'd9, 32'h22222222, 5'd7, 5'd9);
        expect_val("byp_fwd", 0, 1, 32'h22222222);
        expect_val("byp_old", 1, 1, 32'h11111111);
        expect_both("byp_p0", 0, 32'h12345678);
        tick();
        drive(2'b01, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        expect_both("byp_nx0", 0, 32'h22222222);
        expect_both("byp_nx1", 1, 32'h22222222);
        tick();

        // LED shadow
        drive(2'b10, 1'b1, 5'd3, 32'h000000A5, 5'd3, 5'd0);
        expect_both("led_a5", 8, 32'h25);
        expect_val("led_r3_fwd", 0, 0, 32'hA5);
        expect_val("led_r3_old", 1, 0, 32'h0);
        tick();
        drive(2'b01, 1'b1, 5'd3, 32'h0000005A, 5'd3, 5'd3);
        expect_both("led_ph0", 8, 32'h25);
        expect_both("r3_ph0", 0, 32'hA5);
        tick();
        drive(2'b10, 1'b1, 5'd4, 32'h0000007F, 5'd0, 5'd0);
        expect_both("led_r4", 8, 32'h25);
        tick();
        drive(2'b10, 1'b1, 5'd3, 32'hFFFFFF80, 5'd0, 5'd0);
        expect_both("led_hi", 8, 32'h0);
        tick();
        drive(2'b11, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
        expect_both("r4_full", 0, 32'h0000007F);
        expect_both("r3_full", 1, 32'hFFFFFF80);
        tick();
        drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // 4-port, 16-bit instance
        for (int i = 1; i < 8; i++) begin
            b2.CLK_EN = 2'b10; b2.WRITE_ENABLE = 1'b1;
            b2.WRITE_ADDRESS = 3'(i);
            b2.WRITE_DATA = 16'(16'h1000 + i);
            tick();
        end
        b2.CLK_EN = 2'b01; b2.WRITE_ENABLE = 1'b0;
        b2.READ_ADDRESS = {3'd1, 3'd5, 3'd6, 3'd7};
        expect_val("w4_p0", 2, 0, 32'h1007);
        expect_val("w4_p1", 2, 1, 32'h1006);
        expect_val("w4_p2", 2, 2, 32'h1005);
        expect_val("w4_p3", 2, 3, 32'h1001);
        expect_val("w4_led", 2, 8, 32'h03);
        tick();
        b2.READ_ADDRESS = {3'd0, 3'd3, 3'd3, 3'd2};
        expect_val("w4_q0", 2, 0, 32'h1002);
        expect_val("w4_q1", 2, 1, 32'h1003);
        expect_val("w4_q2", 2, 2, 32'h1003);
        expect_val("w4_q3", 2, 3, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the two-port register file used by the core datapath: NUM_READ synchronous read ports, one write port, configurable width and depth.
- Keeps the two-phase CLK_EN scheme and the memory-mapped LED shadow register.
- Adds asynchronous reset, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Implemented as a flop array, not a RAM macro, so the full array resets.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2: number of read ports; legal range 1..4.
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes.
- BYPASS, 1: when 1, a same-cycle write to a read address is forwarded (write-first). When 0, the read returns the old value (read-first).
- LED_ADDR, 3: register address whose writes are mirrored to LEDS.
- LED_WIDTH, 7: LEDS width; must be <= DATA_WIDTH.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CLK_EN  in  2  phase enables: [0] = read phase, [1] = write/commit phase.
- READ_ADDRESS  in  NUM_READ*ADDR_WIDTH  packed read addresses; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- WRITE_ADDRESS  in  ADDR_WIDTH  write address.
- WRITE_ENABLE  in  1  write request.
- WRITE_DATA  in  DATA_WIDTH  write data.
- READ_DATA  out  NUM_READ*DATA_WIDTH  packed registered read data; port i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- LEDS  out  LED_WIDTH  LED shadow register.

Behaviour:
- Reset:
  - RST_N low asynchronously clears every array entry, every READ_DATA port and LEDS to 0.
  - While RST_N is low, all inputs are ignored.
  - The first capture or write occurs on the first rising CLK edge after RST_N deasserts.
- Enables:
  - rd_en = CLK_EN[0] | CLK_EN[1].
  - wr_go = CLK_EN[1] & WRITE_ENABLE.
  - CLK_EN = 2'b00 freezes all state, including READ_DATA and LEDS.
- Read:
  - On a rising edge with rd_en = 1, each port i captures reg[READ_ADDRESS_i] into READ_DATA_i. Latency is 1 cycle.
  - With rd_en = 0, READ_DATA holds its value.
  - Ports are fully independent; any number of ports may read the same address.
- Write:
  - On a rising edge with wr_go = 1, reg[WRITE_ADDRESS] <= WRITE_DATA.
  - If ZERO_REG = 1 and WRITE_ADDRESS = 0, the array write is dropped.
  - WRITE_ENABLE with only CLK_EN[0] set writes nothing.
- Zero register: with ZERO_REG = 1, a read of address 0 always captures 0, including under bypass.
- Simultaneous read/write, same address, same edge (rd_en = 1, wr_go = 1):
  - BYPASS = 1: READ_DATA_i <= WRITE_DATA, except address 0 with ZERO_REG = 1, which captures 0.
  - BYPASS = 0: READ_DATA_i <= the old register value. The new value is visible on the next capture.
- LED shadow:
  - On a rising edge with wr_go = 1 and WRITE_ADDRESS == LED_ADDR, LEDS <= WRITE_DATA[LED_WIDTH-1:0].
  - This applies even when the array write is dropped (LED_ADDR = 0, ZERO_REG = 1).
  - The upper bits of WRITE_DATA are ignored for LEDS; the array stores the full word.
- Reset mid-operation: an RST_N assertion coincident with a write discards the write. Array, READ_DATA and LEDS all read 0 afterwards.
- Width rules:
  - No arithmetic; addresses cover the full 2**ADDR_WIDTH range, so there is no out-of-range case.
  - Elaboration fails if NUM_READ is outside 1..4 or LED_WIDTH > DATA_WIDTH.

Test Plan:
1. Reset: write 0xDEADBEEF to r5 and r3, assert RST_N low mid-cycle -> READ_DATA and LEDS = 0 immediately. After release, a read of r5 and r3 returns 0x00000000.
2. Basic write/read: CLK_EN = 2'b10, WE = 1, write 0x12345678 to r7. Then CLK_EN = 2'b01 with port0 = 7, port1 = 7 -> both ports show 0x12345678 one cycle later. With CLK_EN = 2'b00, a change of READ_ADDRESS leaves outputs unchanged.
3. Zero register: write 0xFFFFFFFF to r0 with CLK_EN = 2'b10 -> a read of r0 on both ports returns 0. A same-edge read of r0 under BYPASS = 1 also returns 0.
4. Bypass: r9 = 0x11111111. On one edge, CLK_EN = 2'b10, write 0x22222222 to r9 while port1 reads r9 -> READ_DATA1 = 0x22222222 with BYPASS = 1, and 0x11111111 with BYPASS = 0 (0x22222222 on the next read).
5. LED shadow: write 0x000000A5 to r3 with CLK_EN = 2'b10 -> LEDS = 7'h25. The same write with CLK_EN = 2'b01 -> LEDS unchanged and r3 unchanged. A write to r4 -> LEDS unchanged.
6. Parametrisation: NUM_READ = 4, DATA_WIDTH = 16, ADDR_WIDTH = 3. Fill r1..r7 with 0x1000+i, then read addresses {7,6,5,1} on the same edge -> 0x1007, 0x1006, 0x1005, 0x1001 on ports 0..3.
